vga_scan_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/pixel_tick_div.sv | 29 ++
 rtl/vga_scan_gen.sv | 128 ++++++++++++
 tb/tb_vga_scan_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, colour constants and small helpers for the
// 640x480@60 scan path and its companion timebases.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int CNT_W = 10;

    typedef logic [CNT_W-1:0] coord_t;
    typedef logic [11:0]      rgb444_t;

    localparam rgb444_t COLOR_BLACK = 12'h000;
    localparam rgb444_t COLOR_WHITE = 12'hFFF;

    // Inclusive range test used for the sync pulse windows.
    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Free-running clock divider producing a one-clock tick every CLK_DIV clocks;
// shared by the scan generator and the game-logic timebase.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Tick is decoded from the counter so the first one lands CLK_DIV-1 edges after reset.
    assign tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel counters, bitmap flag sampling and registered RGB/sync.
// Optional overlay blink (64-frame period) when SCAN_BLINK_EN is defined.
module vga_scan_gen #(
    parameter int                       CLK_DIV  = 4,
    parameter int                       H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int                       H_FP     = vga_timing_pkg::H_FP,
    parameter int                       H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int                       H_BP     = vga_timing_pkg::H_BP,
    parameter int                       V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int                       V_FP     = vga_timing_pkg::V_FP,
    parameter int                       V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int                       V_BP     = vga_timing_pkg::V_BP,
    parameter vga_timing_pkg::rgb444_t  FG_COLOR = vga_timing_pkg::COLOR_WHITE,
    parameter vga_timing_pkg::rgb444_t  BG_COLOR = vga_timing_pkg::COLOR_BLACK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flag_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        pixel_tick,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb
);

    import vga_timing_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic    tick;
    coord_t  h_cnt;
    coord_t  v_cnt;
    logic    h_wrap;
    logic    v_wrap;
    logic    vis;
    logic    flag_eff;
    logic    hsync_p1;
    logic    vsync_p1;
    rgb444_t rgb_p1;

    function automatic rgb444_t pixel_color(input logic visible, input logic flag);
        if (!visible) begin
            return COLOR_BLACK;
        end
        return flag ? FG_COLOR : BG_COLOR;
    endfunction

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Stage p0: scan position, advanced once per pixel tick
    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + coord_t'(1);
            end else begin
                h_cnt <= h_cnt + coord_t'(1);
            end
        end
    end

    assign vis         = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign frame_start = tick && h_wrap && v_wrap;

`ifdef SCAN_BLINK_EN
    logic [5:0] frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 6'd1;
        end
    end

    // Overlay is hidden for the upper half of each 64-frame cycle.
    assign flag_eff = flag_in & ~frame_cnt[5];
`else
    assign flag_eff = flag_in;
`endif

    // Stage p1: colour and sync for the coordinate presented during the tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
            rgb_p1   <= COLOR_BLACK;
        end else if (tick) begin
            hsync_p1 <= !in_window(h_cnt, HS_START, HS_END);
            vsync_p1 <= !in_window(v_cnt, VS_START, VS_END);
            rgb_p1   <= pixel_color(vis, flag_eff);
        end
    end

    assign pixel_x    = h_cnt;
    assign pixel_y    = v_cnt;
    assign video_on   = vis;
    assign pixel_tick = tick;
    assign hsync      = hsync_p1;
    assign vsync      = vsync_p1;
    assign rgb        = rgb_p1;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen on a shrunken raster; the reference model derives
// position, sync and colour from the absolute clock count since reset release.
`timescale 1ns/1ps
module tb_vga_scan_gen;

    localparam int CLK_DIV = 4;
    localparam int HA = 12, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 6,  VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME_TICKS = HT * VT;
    localparam int FRAME_CLKS  = FRAME_TICKS * CLK_DIV;
    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h012;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flag_in = 1'b0;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, pixel_tick, frame_start, hsync, vsync;
    logic [11:0] rgb;

    vga_scan_gen #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .FG_COLOR(FG), .BG_COLOR(BG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flag_in     (flag_in),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .video_on    (video_on),
        .pixel_tick  (pixel_tick),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x;
        int          y;
        logic        vid;
        logic        tick;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          c = 0;
    int          mode = 0;
    logic        r_hs = 1'b1;
    logic        r_vs = 1'b1;
    logic [11:0] r_rgb = 12'h000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic reset_model();
        c     = 0;
        r_hs  = 1'b1;
        r_vs  = 1'b1;
        r_rgb = 12'h000;
    endtask

    // One clock of stimulus: drive flag, push the expected view of this cycle, advance.
    task automatic step();
        exp_t e;
        int   t, x, y;
        logic flag_eff;
        t = c / CLK_DIV;
        x = t % HT;
        y = (t / HT) % VT;
        case (mode)
            0:       flag_in = 1'($urandom_range(0, 1));
            1:       flag_in = (pixel_x[9:2] == 8'd1);
            default: flag_in = 1'b1;
        endcase
        e.x    = x;
        e.y    = y;
        e.vid  = (x < HA) && (y < VA);
        e.tick = ((c % CLK_DIV) == CLK_DIV - 1);
        e.fs   = e.tick && (x == HT - 1) && (y == VT - 1);
        e.hs   = r_hs;
        e.vs   = r_vs;
        e.rgb  = r_rgb;
        exp_q.push_back(e);
        if (e.tick) begin
            flag_eff = flag_in;
`ifdef SCAN_BLINK_EN
            if (((t / FRAME_TICKS) % 64) >= 32) flag_eff = 1'b0;
`endif
            r_hs  = !((x >= HA + HFP) && (x < HA + HFP + HS));
            r_vs  = !((y >= VA + VFP) && (y < VA + VFP + VS));
            r_rgb = !e.vid ? 12'h000 : (flag_eff ? FG : BG);
        end
        @(negedge clk);
        c++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pixel_x"},     32'(pixel_x),     32'd0);
        chk({tag, "_pixel_y"},     32'(pixel_y),     32'd0);
        chk({tag, "_video_on"},    32'(video_on),    32'd1);
        chk({tag, "_pixel_tick"},  32'(pixel_tick),  32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, "_hsync"},       32'(hsync),       32'd1);
        chk({tag, "_vsync"},       32'(vsync),       32'd1);
        chk({tag, "_rgb"},         32'(rgb),         32'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pixel_x",     32'(pixel_x),     32'(e.x));
            chk("pixel_y",     32'(pixel_y),     32'(e.y));
            chk("video_on",    32'(video_on),    32'(e.vid));
            chk("pixel_tick",  32'(pixel_tick),  32'(e.tick));
            chk("frame_start", 32'(frame_start), 32'(e.fs));
            chk("hsync",       32'(hsync),       32'(e.hs));
            chk("vsync",       32'(vsync),       32'(e.vs));
            chk("rgb",         32'(rgb),         32'(e.rgb));
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check_reset_state("por");

        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        mode = 0; run(FRAME_CLKS);
        mode = 1; run(FRAME_CLKS);
        mode = 2; run(FRAME_CLKS);

        // Land mid-pixel at x=15, y=7 where both syncs are active, then reset.
        mode = 0;
        run((7 * HT + 15) * CLK_DIV + 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();

`ifdef SCAN_BLINK_EN
        mode = 2; run(65 * FRAME_CLKS);
`else
        mode = 1; run(FRAME_CLKS);
        mode = 0; run(FRAME_CLKS);
`endif
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
